// File: rtl/instr_queue.sv
// Instruction register fed by a DEPTH-entry prefetch FIFO. Fetch pushes words
// with a valid/ready handshake, and the control unit consumes them with advance.
module instr_queue #(
  parameter  int WIDTH    = 8,
  parameter  int OP_WIDTH = 4,
  parameter  int DEPTH    = 4,
  localparam int CW       = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      clear,
  input  logic [WIDTH-1:0]          in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      advance,
  input  logic                      flush,
  output logic                      ir_valid,
  output logic [OP_WIDTH-1:0]       IR_CU,
  output logic [WIDTH-OP_WIDTH-1:0] IR_DTP,
  output logic [CW-1:0]             count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             ir_valid_q, ir_valid_d;
  logic [WIDTH-1:0] ir_q, ir_d;

  logic push, pop, write_en;

  // in_ready is decoded from registered occupancy only, so it can never form
  // a combinational loop with the fetch side.
  assign in_ready = (count_q != CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (!ir_valid_q || advance) && (count_q != '0);
  assign write_en = push && !flush;

  // NOTE: every variable gets a default at the top of always_comb so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    ir_valid_d = ir_valid_q;
    ir_d       = ir_q;

    if (flush) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      ir_valid_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_d   = rd_ptr_q + AW'(1);
        ir_d       = mem_q[rd_ptr_q];
        ir_valid_d = 1'b1;
      end else if (advance && ir_valid_q) begin
        ir_valid_d = 1'b0;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clear) begin
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      ir_valid_q <= 1'b0;
      ir_q       <= '0;
    end else begin
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      ir_valid_q <= ir_valid_d;
      ir_q       <= ir_d;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // which entries are live, so a reset here would only cost area.
  always_ff @(posedge clk) begin
    if (write_en) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  assign ir_valid = ir_valid_q;
  assign IR_CU    = ir_q[WIDTH-1 -: OP_WIDTH];
  assign IR_DTP   = ir_q[WIDTH-OP_WIDTH-1:0];
  assign count    = count_q;

endmodule

// File: doc/instr_queue.md
# instr_queue

Parametrised instruction register with a built-in prefetch queue. It sits between the instruction-fetch path and the control unit. Fetched instruction words are buffered in a DEPTH-entry FIFO. The head word is transferred into a registered instruction stage, which presents the opcode field to the control unit and the operand field to the datapath. Unlike a single load-enabled register, it decouples fetch from execute with a valid/ready handshake, occupancy reporting and a pipeline flush.

## Interface
- WIDTH, 8: instruction word width in bits.
- OP_WIDTH, 4: opcode field width; opcode = word[WIDTH-1 -: OP_WIDTH], operand = word[WIDTH-OP_WIDTH-1:0]. Constraint: 1 ≤ OP_WIDTH < WIDTH.
- DEPTH, 4: FIFO entries; must be a power of two and ≥ 2.
- CW, $clog2(DEPTH+1): count width, derived (localparam).

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- clear  in  1  synchronous, active-high reset.
- in_data  in  WIDTH  fetched instruction word.
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  FIFO can accept a word this cycle.
- advance  in  1  control unit has consumed the current instruction.
- flush  in  1  discard all buffered and current instructions (branch/jump).
- ir_valid  out  1  IR_CU/IR_DTP hold a live instruction.
- IR_CU  out  OP_WIDTH  registered opcode field.
- IR_DTP  out  WIDTH-OP_WIDTH  registered operand field.
- count  out  CW  FIFO occupancy, 0..DEPTH; excludes the IR stage.

## Operation
- FIFO: circular storage with read and write pointers of $clog2(DEPTH) bits, plus a count register. Pointers wrap naturally from DEPTH-1 to 0.
- in_ready = (count != DEPTH). It is a combinational function of registered state and does not depend on in_valid, advance or flush.
- push = in_valid && in_ready.
  - A push writes in_data at the write pointer.
  - The write pointer increments.
  - A push is never accepted into a full FIFO, even if a pop occurs in the same cycle.
- IR stage load condition: load = (!ir_valid || advance) && (count != 0).
  - On load: {IR_CU, IR_DTP} <= FIFO head, ir_valid <= 1, and the read pointer increments (pop).
- Drain: if advance && ir_valid && count == 0, then ir_valid <= 0. IR_CU/IR_DTP retain their last value.
- advance while ir_valid == 0 has no effect beyond the load rule above.
- count next value = count + push - pop. Simultaneous push and pop leaves count unchanged.
- A word pushed into an empty FIFO is not forwarded to the IR stage in the same cycle; it becomes eligible on the next cycle.
- flush (when clear == 0):
  - Read pointer, write pointer and count go to 0.
  - ir_valid goes to 0.
  - IR_CU/IR_DTP retain their value.
  - flush overrides push and load in the same cycle: in_data is not captured and no load occurs.
- clear has priority over everything. It sets pointers, count, ir_valid, IR_CU and IR_DTP to 0. FIFO storage contents need not be reset.

## Timing
- Reset values: in_ready = 1, ir_valid = 0, IR_CU = 0, IR_DTP = 0, count = 0.
- Latency, empty queue: a word accepted at edge N is visible on IR_CU/IR_DTP with ir_valid = 1 after edge N+1 (2 cycles).
- Throughput: with advance held high and a continuous input stream, one instruction per cycle in steady state.
- Full FIFO: in_ready is low during every cycle in which count == DEPTH. A pop in that cycle raises in_ready on the next cycle.
- Mid-operation clear or flush takes effect on the same edge. In the following cycle in_ready = 1, count = 0 and ir_valid = 0.
- All outputs except in_ready are registered; in_ready is decoded from the count register only.

## Test plan
- Reset: assert clear for 2 cycles with in_valid = 1 → in_ready = 1, ir_valid = 0, IR_CU = 0, IR_DTP = 0, count = 0.
- Single word: push 8'hA5 into an empty queue at edge N → after edge N+1, ir_valid = 1, IR_CU = 4'hA, IR_DTP = 4'h5, count = 0.
- Fill: advance = 0, push 6 words 8'h10..8'h15 on consecutive cycles.
  - Expected: IR = 8'h10, the FIFO holds 8'h11..8'h14, count = 4, in_ready = 0.
  - 8'h15 must not be accepted; the bench holds it until in_ready = 1.
- Drain order: from the full state, hold advance = 1 and stop input → IR shows 8'h11, 8'h12, 8'h13, 8'h14 on successive cycles. ir_valid falls one cycle after the last advance while IR shows 8'h14; IR_CU/IR_DTP stay 4'h1/4'h4.
- Simultaneous push and pop: count = 2, in_valid = 1, advance = 1 with ir_valid = 1 → count stays 2, IR takes the old head, and the new word lands at the tail.
- Flush: count = 3, ir_valid = 1, assert flush together with in_valid and advance.
  - Next cycle: count = 0, ir_valid = 0, in_ready = 1, IR fields unchanged.
  - The next pushed word is the first to reach the IR stage.
